alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one registered ALU_32b between two requesters (e.g. EX stage, branch unit).
//  Accepts one op at a time over valid/ready, drives ALU operation/data_0/data_1, waits the ALU latency, returns tagged result.
//  Sits between requesters and the ALU instance; the ALU's clock is the same clock.
// PARAMETERS
//  ALU_LATENCY  1   clock edges from ALU inputs stable to ALU result/zero valid (>=1)
//  WIDTH        32  data width
// PORTS
//  clock        in   1      single system clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  req0_valid   in   1      requester 0 has an op
//  req0_ready   out  1      requester 0 op accepted this cycle (valid&&ready at edge)
//  req0_op      in   4      ALU operation code
//  req0_a       in   WIDTH  operand -> data_0
//  req0_b       in   WIDTH  operand -> data_1
//  req1_*       -    -      identical set for requester 1
//  rsp_valid    out  1      response available
//  rsp_ready    in   1      consumer takes response (valid&&ready at edge)
//  rsp_id       out  1      requester index of this response
//  rsp_result   out  WIDTH  ALU result
//  rsp_zero     out  1      ALU zero flag
//  busy         out  1      op in flight or response pending
//  alu_operation out 4      to ALU operation
//  alu_data_0   out  WIDTH  to ALU data_0
//  alu_data_1   out  WIDTH  to ALU data_1
//  alu_result   in   WIDTH  from ALU result
//  alu_zero     in   1      from ALU zero
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, rr pointer favours req0, all outputs 0; in-flight op dropped, no response issued.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: reqN_ready = grant to N (combinational, only in IDLE); at most one ready high. Grant: only one valid -> it;
//   both valid -> side pointed to by rr; at accept edge latch op/a/b/id into alu_* regs, cnt<=0, rr<=other id, -> EXEC.
//  EXEC: alu_* held stable; lasts ALU_LATENCY+1 cycles; on last edge capture alu_result/alu_zero into rsp_*, -> RESP.
//  RESP: rsp_valid=1, rsp_* stable until rsp_ready; on rsp_valid&&rsp_ready -> IDLE (rsp_valid drops next cycle).
//  Latency (ALU_LATENCY=1): accept at edge T -> rsp_valid high in cycle T+3; min issue interval ALU_LATENCY+3 cycles.
//  No ready during EXEC/RESP: requesters hold valid/op/operands until ready (no drops, no reordering).
//  rsp_ready high while rsp_valid=0 ignored. busy = (state != IDLE).
//  alu_* retain last op after completion (no toggling when idle).
//  Arithmetic entirely in ALU; arbiter passes operands unchanged, no width change.
// CONFIGURATION
//  ALU_ARB_OPCHECK_EN defined: ops other than 0000,0001,0010,0110,0111,1100 still accepted, ALU not driven
//   (alu_* unchanged), go IDLE->RESP next edge with rsp_result=0, rsp_zero=1, extra out rsp_err=1; rsp_err=0 for legal ops.
//  Undefined: no rsp_err port; every op code passed to ALU unchecked with normal timing.
// TESTING
//  Only req0: AND(0000) a=1 b=3, rsp_ready=1 -> req0_ready one cycle, rsp_valid at T+3, result=1, zero=0, id=0.
//  Both valid after reset: req0 ADD 1+3, req1 SUB 3-1 -> grants req0 then req1; results 4 (id0) then 2 (id1).
//  req0 held valid continuously with req1 valid -> grants alternate 0,1,0,1; none starved.
//  rsp_ready=0 for 5 cycles: SLT 10,30 -> rsp_result=1 held stable, no req ready until consumed, then IDLE.
//  reset_n low during EXEC of NOR 0,0 -> all outputs 0 immediately, no rsp_valid after release; next op normal.
//  OPCHECK_EN: op 0011 -> rsp_err=1, result 0, zero 1, alu_operation unchanged; without macro result = ALU output.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the two-port ALU arbiter.
// With ALU_ARB_OPCHECK_EN defined the response also carries rsp_err.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
`ifdef ALU_ARB_OPCHECK_EN
    logic             rsp_err;
`endif
    logic             busy;
    logic [3:0]       alu_operation;
    logic [WIDTH-1:0] alu_data_0;
    logic [WIDTH-1:0] alu_data_1;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

`ifdef ALU_ARB_OPCHECK_EN
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready, alu_result, alu_zero,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy,
        input  alu_operation, alu_data_0, alu_data_1
    );
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready, alu_result, alu_zero,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy,
        output alu_operation, alu_data_0, alu_data_1
    );
`else
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready, alu_result, alu_zero,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, busy,
        input  alu_operation, alu_data_0, alu_data_1
    );
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready, alu_result, alu_zero,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, busy,
        output alu_operation, alu_data_0, alu_data_1
    );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters, one op at a time.
// Optional ALU_ARB_OPCHECK_EN: illegal op codes bypass the ALU and respond with rsp_err.
module alu_arbiter #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned WIDTH       = 32
) (
    input logic          clock,
    input logic          reset_n,
    alu_arbiter_if.slave bus
);
    localparam int unsigned CntW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             id_q, id_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
`ifdef ALU_ARB_OPCHECK_EN
    logic             err_q, err_d;
    logic             legal;
`endif
    logic             grant0, grant1;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;

    // rr_q == 0 favours requester 0 when both are valid
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
            grant1 = bus.req1_valid && (!bus.req0_valid || rr_q);
        end
    end

    assign sel_op = grant1 ? bus.req1_op : bus.req0_op;
    assign sel_a  = grant1 ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant1 ? bus.req1_b  : bus.req0_b;

`ifdef ALU_ARB_OPCHECK_EN
    assign legal = sel_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
`ifdef ALU_ARB_OPCHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    id_d  = grant1;
                    rr_d  = ~grant1;
                    cnt_d = '0;
`ifdef ALU_ARB_OPCHECK_EN
                    if (!legal) begin
                        // ALU left untouched; respond straight away with a flagged zero result
                        res_d   = '0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        op_d    = sel_op;
                        a_d     = sel_a;
                        b_d     = sel_b;
                        err_d   = 1'b0;
                        state_d = StExec;
                    end
`else
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    state_d = StExec;
`endif
                end
            end
            StExec: begin
                if (cnt_q == CntW'(ALU_LATENCY)) begin
                    res_d   = bus.alu_result;
                    zero_d  = bus.alu_zero;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
`ifdef ALU_ARB_OPCHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.req0_ready    = grant0;
    assign bus.req1_ready    = grant1;
    assign bus.rsp_valid     = (state_q == StResp);
    assign bus.rsp_id        = id_q;
    assign bus.rsp_result    = res_q;
    assign bus.rsp_zero      = zero_q;
`ifdef ALU_ARB_OPCHECK_EN
    assign bus.rsp_err       = err_q;
`endif
    assign bus.busy          = (state_q != StIdle);
    assign bus.alu_operation = op_q;
    assign bus.alu_data_0    = a_q;
    assign bus.alu_data_1    = b_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed and random ops against a grant/result model,
// with a registered one-cycle ALU model attached to the ALU-side ports.
module tb_alu_arbiter;
    localparam int unsigned W = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(.ALU_LATENCY(1), .WIDTH(W)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    bit exp_rr = 1'b0;
    logic [3:0] legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    // Registered ALU, one edge of latency
    always_ff @(posedge clock) begin
        bus.alu_result <= alu_ref(bus.alu_operation, bus.alu_data_0, bus.alu_data_1);
        bus.alu_zero   <= (alu_ref(bus.alu_operation, bus.alu_data_0, bus.alu_data_1) == 32'd0);
    end

    function automatic bit pick(input bit v0, input bit v1, input bit rr);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
        return rr;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        if (n == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic rand_req(input int n);
        logic [31:0] a;
        a = $urandom;
        set_req(n, legal_ops[$urandom_range(0, 5)], a,
                ($urandom_range(0, 3) == 0) ? a : 32'($urandom));
    endtask

    task automatic drop(input int n);
        if (n == 0) bus.req0_valid = 1'b0;
        else bus.req1_valid = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the idle cycle after the handshake.
    task automatic serve(input int hold, input bit keep, input bit illegal);
        bit          gid, eid;
        logic [3:0]  op, prev_op;
        logic [31:0] a, b, er;
        int          w, lat;
        w = 0;
        while (!(bus.req0_ready || bus.req1_ready) && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("grant_seen", 32'(bus.req0_ready | bus.req1_ready), 32'd1);
        if (!(bus.req0_ready || bus.req1_ready)) return;
        chk("one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
        gid = bus.req1_ready;
        eid = pick(bus.req0_valid, bus.req1_valid, exp_rr);
        chk("grant_id", 32'(gid), 32'(eid));
        op      = gid ? bus.req1_op : bus.req0_op;
        a       = gid ? bus.req1_a  : bus.req0_a;
        b       = gid ? bus.req1_b  : bus.req0_b;
        prev_op = bus.alu_operation;
        exp_rr  = !gid;
        lat     = illegal ? 1 : 3;
        er      = illegal ? 32'd0 : alu_ref(op, a, b);
        bus.rsp_ready = (hold == 0);
        @(posedge clock);
        #1;
        if (keep) rand_req(int'(gid));
        else drop(int'(gid));
        for (int c = 1; c < lat; c++) begin
            @(negedge clock);
            chk("rsp_early", 32'(bus.rsp_valid), 32'd0);
            chk("busy_exec", 32'(bus.busy), 32'd1);
            chk("ready_exec", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
            chk("alu_op", 32'(bus.alu_operation), 32'(op));
            chk("alu_d0", bus.alu_data_0, a);
            chk("alu_d1", bus.alu_data_1, b);
        end
        @(negedge clock);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(gid));
        chk("rsp_result", bus.rsp_result, er);
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(er == 32'd0));
`ifdef ALU_ARB_OPCHECK_EN
        chk("rsp_err", 32'(bus.rsp_err), 32'(illegal));
        if (illegal) chk("alu_op_kept", 32'(bus.alu_operation), 32'(prev_op));
`endif
        for (int c = 0; c < hold; c++) begin
            @(negedge clock);
            chk("rsp_hold", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_hold_res", bus.rsp_result, er);
            chk("ready_resp", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bit ill;
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_alu_op", 32'(bus.alu_operation), 32'd0);
        chk("rst_result", bus.rsp_result, 32'd0);
        chk("rst_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        exp_rr = 1'b0;

        // Only req0: AND 1,3
        set_req(0, 4'b0000, 32'd1, 32'd3);
        @(negedge clock);
        serve(0, 1'b0, 1'b0);

        // Both valid after reset: ADD 1+3 on req0, SUB 3-1 on req1
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        exp_rr = 1'b0;
        set_req(0, 4'b0010, 32'd1, 32'd3);
        set_req(1, 4'b0110, 32'd3, 32'd1);
        @(negedge clock);
        chk("both_first_r0", 32'(bus.req0_ready), 32'd1);
        serve(0, 1'b0, 1'b0);
        chk("both_second_r1", 32'(bus.req1_ready), 32'd1);
        serve(0, 1'b0, 1'b0);

        // Both held valid: grants must alternate
        @(posedge clock);
        #1;
        rand_req(0);
        rand_req(1);
        @(negedge clock);
        for (int i = 0; i < 6; i++) serve(int'($urandom_range(0, 2)), 1'b1, 1'b0);
        serve(0, 1'b0, 1'b0);
        serve(0, 1'b0, 1'b0);

        // Consumer stalls 5 cycles on SLT 10,30; req0 re-raised meanwhile
        @(posedge clock);
        #1 set_req(0, 4'b0111, 32'd10, 32'd30);
        @(negedge clock);
        serve(5, 1'b1, 1'b0);
        serve(0, 1'b0, 1'b0);

        // Reset in the middle of EXEC for NOR 0,0
        @(posedge clock);
        #1 set_req(0, 4'b1100, 32'd0, 32'd0);
        @(negedge clock);
        chk("nor_ready", 32'(bus.req0_ready), 32'd1);
        @(posedge clock);
        #1 drop(0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_alu_op", 32'(bus.alu_operation), 32'd0);
        chk("arst_d0", bus.alu_data_0, 32'd0);
        chk("arst_result", bus.rsp_result, 32'd0);
        chk("arst_zero", 32'(bus.rsp_zero), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        exp_rr = 1'b0;
        repeat (5) begin
            @(negedge clock);
            chk("arst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clock);
        #1 set_req(0, 4'b0001, 32'h0000_00f0, 32'h0000_000f);
        @(negedge clock);
        serve(0, 1'b0, 1'b0);

        // Op code 0011: flagged bypass with the option, plain ALU op without it
`ifdef ALU_ARB_OPCHECK_EN
        ill = 1'b1;
`else
        ill = 1'b0;
`endif
        @(posedge clock);
        #1 set_req(1, 4'b0011, 32'd5, 32'd6);
        @(negedge clock);
        serve(1, 1'b0, ill);

        // Random traffic
        for (int i = 0; i < 12; i++) begin
            int v;
            v = int'($urandom_range(1, 3));
            @(posedge clock);
            #1;
            if (v[0]) rand_req(0);
            if (v[1]) rand_req(1);
            @(negedge clock);
            serve(int'($urandom_range(0, 3)), 1'b0, 1'b0);
            if (v == 3) serve(int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
